// File: rtl/i2c_target_regfile.sv
// I2C target with a small byte-addressed register file.
// Oversampled SCL/SDA, open-drain SDA, no clock stretching.
module i2c_target_regfile #(
  parameter logic [6:0] ADDR  = 7'b0101010,
  parameter int         NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i2c_scl,
  inout  wire                      i2c_sda,
  output logic [8*NREGS-1:0]       regs_out,
  output logic                     wr_pulse,
  output logic [$clog2(NREGS)-1:0] wr_addr,
  output logic                     busy
);

  localparam int PW = $clog2(NREGS);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_e;

  state_e state_q, state_d;

  logic scl_s1_q, scl_s2_q, scl_d_q;
  logic sda_s1_q, sda_s2_q, sda_d_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic oe_q, oe_d;
  logic rw_q, rw_d;
  logic busy_q, busy_d;
  logic we;
  logic wr_pulse_q;
  logic [PW-1:0] wr_addr_q;
  logic [7:0] regs_q [NREGS];

  logic scl_rise, scl_fall, start_det, stop_det;
  logic last_bit;
  logic [7:0] byte_in;
  logic [7:0] rd_reg;

  assign scl_rise  = scl_s2_q & ~scl_d_q;
  assign scl_fall  = ~scl_s2_q & scl_d_q;
  assign start_det = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;
  assign last_bit  = (cnt_q == 4'd7);
  assign byte_in   = {sh_q[6:0], sda_s2_q};
  assign rd_reg    = regs_q[ptr_q];

  // Pin synchronizers plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_d_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_d_q  <= 1'b1;
    end else begin
      scl_s1_q <= i2c_scl;
      scl_s2_q <= scl_s1_q;
      scl_d_q  <= scl_s2_q;
      sda_s1_q <= i2c_sda;
      sda_s2_q <= sda_s1_q;
      sda_d_q  <= sda_s2_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: STOP beats START beats bit events
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = S_IDLE;
    end else if (start_det) begin
      state_d = S_ADDR;
    end else begin
      unique case (state_q)
        S_ADDR:
          if (scl_rise && last_bit)
            state_d = (byte_in[7:1] == ADDR) ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:
          if (scl_fall && cnt_q[0])
            state_d = rw_q ? S_RDATA : S_PTR;
        S_PTR:
          if (scl_rise && last_bit) state_d = S_PTR_ACK;
        S_PTR_ACK:
          if (scl_fall && cnt_q[0]) state_d = S_WDATA;
        S_WDATA:
          if (scl_rise && last_bit) state_d = S_WDATA_ACK;
        S_WDATA_ACK:
          if (scl_fall && cnt_q[0]) state_d = S_WDATA;
        S_RDATA:
          if (scl_fall && cnt_q == 4'd8) state_d = S_RDATA_ACK;
        S_RDATA_ACK:
          if (scl_rise && sda_s2_q) state_d = S_IGNORE;
          else if (scl_fall && cnt_q[0]) state_d = S_RDATA;
        default: ;
      endcase
    end
  end

  // Datapath and SDA drive; ACK slots use cnt_q[0] as assert/release phase
  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    ptr_d  = ptr_q;
    oe_d   = oe_q;
    rw_d   = rw_q;
    busy_d = busy_q;
    we     = 1'b0;
    if (stop_det) begin
      cnt_d  = '0;
      oe_d   = 1'b0;
      busy_d = 1'b0;
    end else if (start_det) begin
      cnt_d = '0;
      oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            sh_d  = byte_in;
            cnt_d = last_bit ? 4'd0 : cnt_q + 4'd1;
            if (last_bit) begin
              if (state_q == S_ADDR) begin
                rw_d = sda_s2_q;
                if (byte_in[7:1] == ADDR) busy_d = 1'b1;
              end else if (state_q == S_PTR) begin
                ptr_d = byte_in[PW-1:0];
              end else begin
                we    = 1'b1;
                ptr_d = ptr_q + 1'b1;
              end
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!cnt_q[0]) begin
              oe_d  = 1'b1;
              cnt_d = 4'd1;
            end else begin
              cnt_d = '0;
              oe_d  = 1'b0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                sh_d = {rd_reg[6:0], 1'b1};
                oe_d = ~rd_reg[7];
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              cnt_d = '0;
              oe_d  = 1'b0;
              ptr_d = ptr_q + 1'b1;
            end else begin
              oe_d = ~sh_q[7];
              sh_d = {sh_q[6:0], 1'b1};
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise && !sda_s2_q) begin
            cnt_d = 4'd1;
          end else if (scl_fall && cnt_q[0]) begin
            cnt_d = '0;
            sh_d  = {rd_reg[6:0], 1'b1};
            oe_d  = ~rd_reg[7];
          end
        end
        default: oe_d = 1'b0;
      endcase
    end
  end

  // Datapath registers and register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      sh_q       <= '0;
      ptr_q      <= '0;
      oe_q       <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      wr_pulse_q <= we;
      if (we) begin
        wr_addr_q     <= ptr_q;
        regs_q[ptr_q] <= byte_in;
      end
    end
  end

  // Outputs
  always_comb begin
    for (int k = 0; k < NREGS; k++) regs_out[8*k +: 8] = regs_q[k];
  end

  assign i2c_sda  = oe_q ? 1'b0 : 1'bz;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C controller
// against a transaction-level register-file model.
module tb_i2c_target_regfile;

  localparam int N = 4;
  localparam int Q = 60;

  logic clk = 1'b0;
  logic rst;
  logic scl;
  logic tb_oe;
  wire  sda_bus;
  logic [8*N-1:0] regs_out;
  logic wr_pulse;
  logic [1:0] wr_addr;
  logic busy;

  pullup (sda_bus);
  assign sda_bus = tb_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target_regfile #(.ADDR(7'b0101010), .NREGS(N)) dut (
    .clk(clk), .rst(rst), .i2c_scl(scl), .i2c_sda(sda_bus),
    .regs_out(regs_out), .wr_pulse(wr_pulse),
    .wr_addr(wr_addr), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  int pulses = 0;
  int drv_cnt = 0;
  int busy_cnt = 0;
  int addr_log [256];
  logic [7:0] val_log [256];

  always @(negedge clk) begin
    if (wr_pulse) begin
      if (pulses < 256) begin
        addr_log[pulses] = int'(wr_addr);
        val_log[pulses] = regs_out[8*wr_addr +: 8];
      end
      pulses = pulses + 1;
    end
    if (!tb_oe && sda_bus === 1'b0) drv_cnt = drv_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  logic [7:0] mreg [N];
  int mptr;

  function automatic logic [31:0] mflat();
    logic [31:0] f;
    for (int k = 0; k < N; k++) f[8*k +: 8] = mreg[k];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    tb_oe = 1'b0; #Q;
    scl = 1'b1; #Q;
    tb_oe = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    tb_oe = 1'b1; #Q;
    scl = 1'b1; #Q;
    tb_oe = 1'b0; #(2*Q);
  endtask

  task automatic put_bit(input logic b);
    tb_oe = ~b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    tb_oe = 1'b0; #Q;
    scl = 1'b1; #Q;
    b = (sda_bus !== 1'b0); #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
  endtask

  task automatic do_write(input logic [7:0] ab, input logic [7:0] p,
                          input logic [7:0] d[$]);
    logic a;
    int p0, d0, b0;
    bit hit;
    int ea[$];
    logic [7:0] ev[$];
    p0 = pulses; d0 = drv_cnt; b0 = busy_cnt;
    hit = (ab[7:1] == 7'h2A) && !ab[0];
    i2c_start();
    put_byte(ab, a);
    chk("addr_ack", a, hit);
    if (hit) chk("busy_hi", busy, 1'b1);
    put_byte(p, a);
    chk("ptr_ack", a, hit);
    if (hit) mptr = p % N;
    foreach (d[i]) begin
      put_byte(d[i], a);
      chk("data_ack", a, hit);
      if (hit) begin
        mreg[mptr] = d[i];
        ea.push_back(mptr);
        ev.push_back(d[i]);
        mptr = (mptr + 1) % N;
      end
    end
    i2c_stop();
    chk("busy_lo", busy, 1'b0);
    chk("pulses", pulses - p0, ea.size());
    foreach (ea[i]) begin
      if (p0 + i < 256 && p0 + i < pulses) begin
        chk("wr_addr", addr_log[p0+i], ea[i]);
        chk("wr_val", val_log[p0+i], ev[i]);
      end
    end
    chk("regs", regs_out, mflat());
    if (!hit) begin
      chk("nodrive", drv_cnt - d0, 0);
      chk("nobusy", busy_cnt - b0, 0);
    end
  endtask

  task automatic do_read(input logic [7:0] p, input int n);
    logic a;
    logic [7:0] v;
    int p0;
    p0 = pulses;
    i2c_start();
    put_byte(8'h54, a);
    chk("rd_waddr_ack", a, 1'b1);
    put_byte(p, a);
    chk("rd_ptr_ack", a, 1'b1);
    mptr = p % N;
    i2c_start();
    put_byte(8'h55, a);
    chk("rd_raddr_ack", a, 1'b1);
    for (int i = 0; i < n; i++) begin
      get_byte(v);
      chk("rdata", v, mreg[mptr]);
      mptr = (mptr + 1) % N;
      put_bit(i == n - 1);
    end
    #Q;
    chk("rd_released", sda_bus !== 1'b0, 1'b1);
    i2c_stop();
    chk("rd_busy_lo", busy, 1'b0);
    chk("rd_nopulse", pulses - p0, 0);
  endtask

  initial begin
    logic [7:0] dq[$];
    logic [7:0] v, ab;
    logic a, b;
    int p0, k, op, len;

    rst = 1'b0; scl = 1'b1; tb_oe = 1'b0;
    for (int i = 0; i < N; i++) mreg[i] = 8'h00;
    mptr = 0;
    #35;
    chk("rst_sda", sda_bus !== 1'b0, 1'b1);
    chk("rst_regs", regs_out, 32'h0);
    chk("rst_wr_pulse", wr_pulse, 1'b0);
    chk("rst_wr_addr", wr_addr, 2'd0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    #100;

    // Single write
    dq = {8'hA5};
    do_write(8'h54, 8'h01, dq);
    chk("single_reg1", regs_out[15:8], 8'hA5);

    // Burst write with pointer wrap
    dq = {8'h11, 8'h22};
    do_write(8'h54, 8'h03, dq);
    chk("wrap_reg3", regs_out[31:24], 8'h11);
    chk("wrap_reg0", regs_out[7:0], 8'h22);

    // Wrong address
    dq.delete();
    do_write(8'h56, 8'hFF, dq);

    // Read with repeated START
    dq = {8'h11, 8'h22, 8'h33, 8'h44};
    do_write(8'h54, 8'h00, dq);
    do_read(8'h01, 2);

    // Aborted byte
    p0 = pulses;
    i2c_start();
    put_byte(8'h54, a);
    chk("ab_addr_ack", a, 1'b1);
    put_byte(8'h00, a);
    chk("ab_ptr_ack", a, 1'b1);
    mptr = 0;
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    i2c_stop();
    chk("ab_nopulse", pulses - p0, 0);
    chk("ab_regs", regs_out, mflat());
    chk("ab_busy", busy, 1'b0);

    // Randomized mix
    for (int it = 0; it < 8; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        len = $urandom_range(1, 5);
        dq.delete();
        for (int i = 0; i < len; i++) dq.push_back(8'($urandom));
        do_write(8'h54, 8'($urandom), dq);
      end else if (op == 1) begin
        do_read(8'($urandom), $urandom_range(1, 4));
      end else begin
        ab = 8'($urandom);
        if (ab[7:1] == 7'h2A) ab[7:1] = 7'h2B;
        dq = {8'($urandom)};
        do_write(ab, 8'($urandom), dq);
      end
    end

    // Reset during the 3rd bit of a read byte that drives a 0 there
    k = $urandom_range(1, N - 1);
    v = 8'($urandom) & 8'hDF;
    dq = {v};
    do_write(8'h54, 8'(k), dq);
    i2c_start();
    put_byte(8'h54, a);
    put_byte(8'(k), a);
    i2c_start();
    put_byte(8'h55, a);
    chk("rr_ack", a, 1'b1);
    get_bit(b);
    chk("rr_bit7", b, v[7]);
    get_bit(b);
    chk("rr_bit6", b, v[6]);
    chk("rr_drive_low", sda_bus === 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    chk("rr_sda_rel", sda_bus !== 1'b0, 1'b1);
    chk("rr_regs", regs_out, 32'h0);
    chk("rr_wr_pulse", wr_pulse, 1'b0);
    chk("rr_wr_addr", wr_addr, 2'd0);
    chk("rr_busy", busy, 1'b0);
    for (int i = 0; i < N; i++) mreg[i] = 8'h00;
    mptr = 0;
    tb_oe = 1'b0;
    scl = 1'b1;
    #100;
    rst = 1'b1;
    #100;
    dq = {8'($urandom), 8'($urandom)};
    do_write(8'h54, 8'($urandom), dq);
    do_read(8'h00, N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
